// File: rtl/formula_pkg.sv
// Shared widths and stage payload types for the formula pipeline.
// The payload structs are sized for P_WIDTH, so any WIDTH override of formula must change P_WIDTH too.
package formula_pkg;

    localparam int P_WIDTH = 8;

    function automatic int diff_w(input int width);
        return width + 1;
    endfunction

    function automatic int t_w(input int width);
        return width + 2;
    endfunction

    function automatic int res_w(input int width);
        return 2 * width + 3;
    endfunction

    localparam int DIFF_W = diff_w(P_WIDTH);
    localparam int T_W    = t_w(P_WIDTH);
    localparam int RES_W  = res_w(P_WIDTH);

    typedef struct packed {
        logic signed [DIFF_W-1:0] diff;
        logic signed [T_W-1:0]    t;
        logic signed [T_W-1:0]    d4;
    } s1_payload_t;

    typedef struct packed {
        logic signed [RES_W-1:0] prod;
        logic signed [T_W-1:0]   d4;
    } s2_payload_t;

endpackage

// File: rtl/formula_pipe_reg.sv
// One valid/ready register slice; it accepts new data whenever it is empty or its content is leaving.
module formula_pipe_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // NOTE: ready is combinational from downstream, so a full pipe can pop and push in the same cycle.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // rst_n is active-high here despite its name.
    // NOTE: the data register is reset as well as the valid bit, so the output reads 0 during reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            // NOTE: non-blocking assignments keep every stage sampling the pre-edge values of its neighbours.
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/formula.sv
// Streaming q = ((a - b) * (1 + 3*c) + 4*d) >>> 1 over three valid/ready register slices.
// The arithmetic sits in front of each slice; the last slice holds q directly.
module formula
    import formula_pkg::*;
#(
    parameter int WIDTH = P_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    input  logic signed [WIDTH-1:0]   c,
    input  logic signed [WIDTH-1:0]   d,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic signed [2*WIDTH+2:0] q,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic signed [DIFF_W-1:0] w_diff;
    logic signed [T_W-1:0]    w_c_ext;
    logic signed [T_W-1:0]    w_t;
    logic signed [T_W-1:0]    w_d4;
    s1_payload_t              w_s1_in;
    s1_payload_t              w_s1_q;
    logic                     w_s1_valid;
    logic                     w_s2_ready;

    s2_payload_t              w_s2_in;
    s2_payload_t              w_s2_q;
    logic                     w_s2_valid;
    logic                     w_s3_ready;

    logic signed [RES_W-1:0]  w_sum;
    logic signed [RES_W-1:0]  w_s3_in;

    // 3*c + 1 is formed as c + 2c + 1 so no multiplier is needed ahead of stage 1.
    assign w_c_ext = T_W'(c);
    assign w_diff  = DIFF_W'(a) - DIFF_W'(b);
    assign w_t     = w_c_ext + (w_c_ext <<< 1) + T_W'(1);
    assign w_d4    = T_W'(d) <<< 2;

    always_comb begin
        w_s1_in      = '0;
        w_s1_in.diff = w_diff;
        w_s1_in.t    = w_t;
        w_s1_in.d4   = w_d4;
    end

    formula_pipe_reg #(.DATA_W($bits(s1_payload_t))) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_valid),
        .i_data  (w_s1_in),
        .o_ready (in_ready),
        .o_valid (w_s1_valid),
        .o_data  (w_s1_q),
        .i_ready (w_s2_ready)
    );

    always_comb begin
        w_s2_in      = '0;
        w_s2_in.prod = RES_W'(signed'(w_s1_q.diff)) * RES_W'(signed'(w_s1_q.t));
        w_s2_in.d4   = w_s1_q.d4;
    end

    formula_pipe_reg #(.DATA_W($bits(s2_payload_t))) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_s1_valid),
        .i_data  (w_s2_in),
        .o_ready (w_s2_ready),
        .o_valid (w_s2_valid),
        .o_data  (w_s2_q),
        .i_ready (w_s3_ready)
    );

    // Arithmetic shift floors toward -inf, which is the intended rounding.
    assign w_sum   = signed'(w_s2_q.prod) + RES_W'(signed'(w_s2_q.d4));
    assign w_s3_in = w_sum >>> 1;

    formula_pipe_reg #(.DATA_W(RES_W)) u_s3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_s2_valid),
        .i_data  (w_s3_in),
        .o_ready (w_s3_ready),
        .o_valid (out_valid),
        .o_data  (q),
        .i_ready (out_ready)
    );

endmodule

// File: tb/tb_formula.sv
// Randomised and directed bench for formula against a queue-based reference model.
module tb_formula;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [7:0] a, b, c, d;
    logic              in_valid;
    logic              in_ready;
    logic signed [18:0] q;
    logic              out_valid;
    logic              out_ready;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    int exp_q[$];
    bit prev_stall = 1'b0;
    logic signed [18:0] prev_q = '0;

    int acc;
    bit took;
    bit seen;
    int pa, pb, pc, pd;

    formula #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: exact integer formula, then floor division by two.
    function automatic int ref_q(input int ia, input int ib, input int ic, input int id);
        int e;
        e = (ia - ib) * (1 + 3 * ic) + 4 * id;
        return (e - (e & 1)) / 2;
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic set_ops(input int ia, input int ib, input int ic, input int id);
        a = 8'(ia);
        b = 8'(ib);
        c = 8'(ic);
        d = 8'(id);
    endtask

    // Scoreboard: record accepted inputs, compare every popped output, watch stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", longint'(out_valid), 1);
                check("hold_q", q, prev_q);
            end
            if (out_valid && out_ready) begin
                check("out_has_expected", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    check("stream_q", q, exp_q.pop_front());
                    pops++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_q(a, b, c, d));
            end
            prev_stall = out_valid && !out_ready;
            prev_q     = q;
        end
    end

    task automatic push(input int ia, input int ib, input int ic, input int id);
        int n;
        n = 0;
        set_ops(ia, ib, ic, id);
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                check("push_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (exp_q.size() != 0 && n < 100);
        check("drain_empty", exp_q.size(), 0);
        check("drain_idle", longint'(out_valid), 0);
    endtask

    task automatic run_single(input string tag, input int ia, input int ib, input int ic,
                              input int id, input int exp);
        int lat;
        bit got_valid;
        lat = 0;
        got_valid = 1'b0;
        push(ia, ib, ic, id);
        for (int i = 1; i <= 20 && !got_valid; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got_valid = 1'b1;
                lat = i;
            end
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_q"}, q, exp);
        wait_empty();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_ops(0, 0, 0, 0);
        #1 rst_n = 1'b1;
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_q", q, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        check("rel_in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;

        run_single("basic", 5, 2, 1, 3, 12);
        run_single("ext_pos", 127, -128, 127, 127, 48959);
        run_single("ext_neg", -128, 127, 127, -128, -48961);
        run_single("floor_neg", 0, 1, 0, 0, -1);
        run_single("floor_pos", 1, 0, 0, 0, 0);

        // Back-to-back streaming: ten results on ten consecutive cycles.
        out_ready = 1'b1;
        fork
            for (int i = 0; i < 10; i++) push(rnd8(), rnd8(), rnd8(), rnd8());
            begin : stream_mon
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    seen = out_valid;
                end
                check("stream_first", longint'(seen), 1);
                for (int i = 0; i < 9; i++) begin
                    @(negedge clk);
                    check("stream_tput", longint'(out_valid), 1);
                end
            end
        join
        wait_empty();
        check("stream_pops", pops, 15);

        // Backpressure: the pipe fills to three items and then refuses input.
        out_ready = 1'b0;
        acc = 0;
        set_ops(rnd8(), rnd8(), rnd8(), rnd8());
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            took = in_ready;
            if (took) acc++;
            @(posedge clk);
            #1;
            if (took) set_ops(rnd8(), rnd8(), rnd8(), rnd8());
        end
        check("bp_accepted", acc, 3);
        @(negedge clk);
        check("bp_in_ready_low", longint'(in_ready), 0);
        check("bp_out_valid", longint'(out_valid), 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_pushpop_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_empty();
        check("bp_pops", pops, 19);

        // Mid-operation reset with items in flight and one stalled at the output.
        out_ready = 1'b0;
        push(5, 2, 1, 3);
        push(-7, 3, 2, -1);
        @(posedge clk);
        @(posedge clk);
        #3;
        check("rst_pre_valid", longint'(out_valid), 1);
        rst_n = 1'b1;
        #1;
        check("rst_mid_out_valid", longint'(out_valid), 0);
        check("rst_mid_q", q, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_rel_in_ready", longint'(in_ready), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_spurious", longint'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        pa = rnd8();
        pb = rnd8();
        pc = rnd8();
        pd = rnd8();
        run_single("post_rst", pa, pb, pc, pd, ref_q(pa, pb, pc, pd));
        check("total_pops", pops, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
